scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/scoreboard_regfile.sv | 151 +++++++++++++++
 tb/tb_scoreboard_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// Register file with two write ports, a dedicated special-register write port
// and a per-register busy scoreboard. Issues mark a destination pending;
// any write to that register clears the pending bit unless a new issue to
// the same register lands on the same edge. Read ports can optionally see
// same-cycle write data.
//
// Handshake: no valid/ready flow control. wr_enN, sp_wr_en and iss_valid are
// single-cycle qualifiers sampled on each rising clk edge; nothing is ever
// back-pressured. All read-side outputs are combinational.
module scoreboard_regfile #(
   parameter int DW       = 16,
   parameter int NREG     = 16,
   parameter int SP_IDX   = NREG - 1,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1,
   localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [AW-1:0]      rd_addr1,
   input  logic [AW-1:0]      rd_addr2,
   output logic [DW-1:0]      rd_data1,
   output logic [DW-1:0]      rd_data2,
   output logic               rd_busy1,
   output logic               rd_busy2,
   input  logic               wr_en1,
   input  logic [AW-1:0]      wr_addr1,
   input  logic [DW-1:0]      wr_data1,
   input  logic               wr_en2,
   input  logic [AW-1:0]      wr_addr2,
   input  logic [DW-1:0]      wr_data2,
   input  logic               sp_wr_en,
   input  logic [DW-1:0]      sp_wr_data,
   output logic [DW-1:0]      sp_data,
   input  logic               iss_valid,
   input  logic [AW-1:0]      iss_dst,
   output logic [NREG-1:0]    busy_vec,
   output logic [AW:0]        busy_cnt,
   output logic [NREG*DW-1:0] regout
);

   localparam logic [AW:0]   LP_NREG = (AW+1)'(NREG);
   localparam logic [AW-1:0] LP_SP   = AW'(SP_IDX);
   localparam logic [AW:0]   LP_ONE  = (AW+1)'(1);

   logic [DW-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;
   logic [AW:0] r_busy_cnt;

   logic w_wr1_ok, w_wr2_ok, w_sp_ok, w_iss_ok;
   logic [NREG-1:0] w_we;
   logic [DW-1:0] w_wd [NREG];
   logic [NREG-1:0] w_iss_set;
   logic [NREG-1:0] w_busy_nxt;
   logic [AW:0] w_inc, w_dec, w_cnt_nxt;

   // An address is usable when it exists and is not the hardwired zero register.
   function automatic logic f_addr_ok(input logic [AW-1:0] a);
      f_addr_ok = ({1'b0, a} < LP_NREG) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Qualify every port; reset masks them so bypassed reads also read as zero.
   always_comb begin
      w_wr1_ok = !reset && wr_en1    && f_addr_ok(wr_addr1);
      w_wr2_ok = !reset && wr_en2    && f_addr_ok(wr_addr2);
      w_sp_ok  = !reset && sp_wr_en  && f_addr_ok(LP_SP);
      w_iss_ok = !reset && iss_valid && f_addr_ok(iss_dst);
   end

   // Per-register write resolve (sp > wr2 > wr1) and next busy bits.
   always_comb begin
      w_we       = '0;
      w_iss_set  = '0;
      w_busy_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         w_wd[i] = '0;
         if (w_wr1_ok && (wr_addr1 == AW'(i))) begin
            w_we[i] = 1'b1;
            w_wd[i] = wr_data1;
         end
         if (w_wr2_ok && (wr_addr2 == AW'(i))) begin
            w_we[i] = 1'b1;
            w_wd[i] = wr_data2;
         end
         if (w_sp_ok && (i == SP_IDX)) begin
            w_we[i] = 1'b1;
            w_wd[i] = sp_wr_data;
         end
         w_iss_set[i]  = w_iss_ok && (iss_dst == AW'(i));
         // A new issue wins over a write clearing the same register.
         w_busy_nxt[i] = w_iss_set[i] || (r_busy[i] && !w_we[i]);
      end
   end

   // Busy counter follows the net number of bits set and cleared this edge.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int i = 0; i < NREG; i++) begin
         if (w_busy_nxt[i] && !r_busy[i]) w_inc = w_inc + LP_ONE;
         if (!w_busy_nxt[i] && r_busy[i]) w_dec = w_dec + LP_ONE;
      end
      w_cnt_nxt = r_busy_cnt + w_inc - w_dec;
   end

   // Read ports: stored value, or same-cycle write data when bypass is enabled.
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      rd_busy1 = 1'b0;
      rd_busy2 = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (rd_addr1 == AW'(i)) begin
            rd_data1 = ((BYPASS != 0) && w_we[i]) ? w_wd[i] : r_regs[i];
            rd_busy1 = r_busy[i] && !((BYPASS != 0) && w_we[i]);
         end
         if (rd_addr2 == AW'(i)) begin
            rd_data2 = ((BYPASS != 0) && w_we[i]) ? w_wd[i] : r_regs[i];
            rd_busy2 = r_busy[i] && !((BYPASS != 0) && w_we[i]);
         end
      end
   end

   // Flattened register view, register 0 in the most significant slot.
   always_comb begin
      regout = '0;
      for (int i = 0; i < NREG; i++) begin
         regout[(NREG-1-i)*DW +: DW] = r_regs[i];
      end
   end

   assign sp_data  = r_regs[SP_IDX];
   assign busy_vec = r_busy;
   assign busy_cnt = r_busy_cnt;

   // Register storage, scoreboard bits and counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_we[i]) r_regs[i] <= w_wd[i];
         end
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile. Two instances share all inputs:
// u_dut uses defaults, u_zb has ZERO_REG=1 and BYPASS=0.
module tb_scoreboard_regfile;

   localparam int DW   = 16;
   localparam int NREG = 16;
   localparam int AW   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2, iss_dst;
   logic [DW-1:0] wr_data1, wr_data2, sp_wr_data;
   logic wr_en1, wr_en2, sp_wr_en, iss_valid;

   logic [DW-1:0] a_rd_data1, a_rd_data2, a_sp_data;
   logic a_rd_busy1, a_rd_busy2;
   logic [NREG-1:0] a_busy_vec;
   logic [AW:0] a_busy_cnt;
   logic [NREG*DW-1:0] a_regout;

   logic [DW-1:0] z_rd_data1, z_rd_data2, z_sp_data;
   logic z_rd_busy1, z_rd_busy2;
   logic [NREG-1:0] z_busy_vec;
   logic [AW:0] z_busy_cnt;
   logic [NREG*DW-1:0] z_regout;

   int n_cmp = 0;
   int n_bad = 0;

   scoreboard_regfile #(.DW(DW), .NREG(NREG)) u_dut (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(a_rd_data1), .rd_data2(a_rd_data2),
      .rd_busy1(a_rd_busy1), .rd_busy2(a_rd_busy2),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .sp_data(a_sp_data),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .busy_vec(a_busy_vec), .busy_cnt(a_busy_cnt), .regout(a_regout)
   );

   scoreboard_regfile #(.DW(DW), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) u_zb (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(z_rd_data1), .rd_data2(z_rd_data2),
      .rd_busy1(z_rd_busy1), .rd_busy2(z_rd_busy2),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .sp_wr_en(sp_wr_en), .sp_wr_data(sp_wr_data), .sp_data(z_sp_data),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .busy_vec(z_busy_vec), .busy_cnt(z_busy_cnt), .regout(z_regout)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en1 = 1'b0; wr_en2 = 1'b0; sp_wr_en = 1'b0; iss_valid = 1'b0;
   endtask

   task automatic drv_wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en1 = 1'b1; wr_addr1 = a; wr_data1 = d;
   endtask

   task automatic drv_wr2(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
   endtask

   task automatic drv_iss(input logic [AW-1:0] a);
      iss_valid = 1'b1; iss_dst = a;
   endtask

   function automatic logic [DW-1:0] reg_of(input logic [NREG*DW-1:0] v, input int i);
      return v[(NREG-1-i)*DW +: DW];
   endfunction

   initial begin
      idle();
      rd_addr1 = '0; rd_addr2 = '0; wr_addr1 = '0; wr_addr2 = '0; iss_dst = '0;
      wr_data1 = '0; wr_data2 = '0; sp_wr_data = '0;

      // Reset held with activity on the inputs: nothing may leak out.
      drv_wr1(4'd3, 16'hDEAD);
      drv_iss(4'd1);
      rd_addr1 = 4'd3;
      tick();
      tick();
      chk("rst_rd_data1", 32'(a_rd_data1), 32'h0);
      chk("rst_busy_cnt", 32'(a_busy_cnt), 32'h0);
      chk("rst_busy_vec", 32'(a_busy_vec), 32'h0);
      chk("rst_regout_nz", 32'(a_regout != '0), 32'h0);
      idle();
      reset = 1'b0;

      // Single write then read back.
      drv_wr1(4'd3, 16'h1234);
      tick();
      idle();
      rd_addr1 = 4'd3;
      #1;
      chk("wr1_rd_data1", 32'(a_rd_data1), 32'h1234);
      chk("wr1_regout3", 32'(reg_of(a_regout, 3)), 32'h1234);

      // Collision on reg 5 (wr2 wins) plus sp write to reg 15.
      drv_wr1(4'd5, 16'hAAAA);
      drv_wr2(4'd5, 16'h5555);
      sp_wr_en = 1'b1; sp_wr_data = 16'h00FF;
      rd_addr2 = 4'd5;
      #1;
      chk("byp_prio_rd2", 32'(a_rd_data2), 32'h5555);
      tick();
      idle();
      chk("prio_reg5", 32'(reg_of(a_regout, 5)), 32'h5555);
      chk("sp_reg15", 32'(a_sp_data), 32'h00FF);
      // wr1 to reg 15 loses against sp.
      drv_wr1(4'd15, 16'h1111);
      sp_wr_en = 1'b1; sp_wr_data = 16'h2222;
      tick();
      idle();
      chk("sp_beats_wr1", 32'(a_sp_data), 32'h2222);
      chk("sp_regout15", 32'(reg_of(a_regout, 15)), 32'h2222);

      // Issue reg 7, then a bypassed write clears it.
      drv_iss(4'd7);
      tick();
      idle();
      rd_addr2 = 4'd7;
      #1;
      chk("iss7_busy_bit", 32'(a_busy_vec[7]), 32'h1);
      chk("iss7_busy_cnt", 32'(a_busy_cnt), 32'h1);
      chk("iss7_rd_busy2", 32'(a_rd_busy2), 32'h1);
      drv_wr2(4'd7, 16'hBEEF);
      #1;
      chk("byp_rd_data2", 32'(a_rd_data2), 32'hBEEF);
      chk("byp_rd_busy2", 32'(a_rd_busy2), 32'h0);
      tick();
      idle();
      chk("wr7_busy_cnt", 32'(a_busy_cnt), 32'h0);
      chk("wr7_rd_data2", 32'(a_rd_data2), 32'hBEEF);

      // Issue and write to the same register: the issue wins.
      drv_iss(4'd4);
      drv_wr1(4'd4, 16'h4444);
      tick();
      idle();
      chk("iss_wins_bit4", 32'(a_busy_vec[4]), 32'h1);
      chk("iss_wins_cnt", 32'(a_busy_cnt), 32'h1);
      drv_wr1(4'd4, 16'h0000);
      tick();
      idle();
      chk("clr4_cnt", 32'(a_busy_cnt), 32'h0);

      // Two pending, two writes in one cycle: count 2 -> 0.
      drv_iss(4'd2);
      tick();
      drv_iss(4'd3);
      tick();
      idle();
      chk("two_busy_cnt", 32'(a_busy_cnt), 32'h2);
      chk("two_busy_vec", 32'(a_busy_vec), 32'h000C);
      drv_wr1(4'd2, 16'h2222);
      drv_wr2(4'd3, 16'h3333);
      tick();
      idle();
      chk("dbl_clr_cnt", 32'(a_busy_cnt), 32'h0);
      chk("dbl_clr_vec", 32'(a_busy_vec), 32'h0);

      // Zero register: write and issue to reg 0 are dropped in u_zb only.
      drv_wr1(4'd0, 16'hFFFF);
      drv_iss(4'd0);
      rd_addr1 = 4'd0;
      #1;
      chk("zb_byp_rd0", 32'(z_rd_data1), 32'h0);
      tick();
      idle();
      chk("zb_rd_data0", 32'(z_rd_data1), 32'h0);
      chk("zb_busy0", 32'(z_busy_vec[0]), 32'h0);
      chk("zb_rd_busy0", 32'(z_rd_busy1), 32'h0);
      chk("zb_cnt", 32'(z_busy_cnt), 32'h0);
      chk("def_rd_data0", 32'(a_rd_data1), 32'hFFFF);
      chk("def_busy0", 32'(a_busy_vec[0]), 32'h1);

      // No bypass in u_zb: old value during the write cycle. Also clear reg 0.
      drv_wr1(4'd3, 16'h9999);
      drv_wr2(4'd0, 16'h0000);
      rd_addr1 = 4'd3;
      #1;
      chk("zb_nobyp_old", 32'(z_rd_data1), 32'h3333);
      chk("def_byp_new", 32'(a_rd_data1), 32'h9999);
      tick();
      idle();
      chk("zb_after_wr3", 32'(z_rd_data1), 32'h9999);
      chk("def_clr0_cnt", 32'(a_busy_cnt), 32'h0);

      // Three pending, then asynchronous reset mid-cycle.
      drv_iss(4'd8);
      tick();
      drv_iss(4'd9);
      tick();
      drv_iss(4'd10);
      tick();
      idle();
      chk("pre_rst_cnt", 32'(a_busy_cnt), 32'h3);
      drv_wr1(4'd3, 16'h7777);
      drv_iss(4'd11);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_cnt", 32'(a_busy_cnt), 32'h0);
      chk("arst_vec", 32'(a_busy_vec), 32'h0);
      chk("arst_regout_nz", 32'(a_regout != '0), 32'h0);
      chk("arst_sp", 32'(a_sp_data), 32'h0);
      chk("arst_rd_data1", 32'(a_rd_data1), 32'h0);
      chk("arst_zb_regout_nz", 32'(z_regout != '0), 32'h0);
      tick();
      chk("arst_hold_cnt", 32'(a_busy_cnt), 32'h0);
      chk("arst_hold_reg3", 32'(reg_of(a_regout, 3)), 32'h0);
      idle();
      reset = 1'b0;

      // First edge after reset release accepts a write and an issue.
      drv_wr1(4'd6, 16'h6666);
      drv_iss(4'd12);
      tick();
      idle();
      chk("post_rst_reg6", 32'(reg_of(a_regout, 6)), 32'h6666);
      chk("post_rst_cnt", 32'(a_busy_cnt), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
